// File: rtl/pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub_pkg
// Purpose  : Operation encodings and flag indices shared by the pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  // Carry injected into bit 0; SUB/SBB turn borrow semantics into add-of-complement.
  function automatic logic op_carry_in(input op_e op, input logic cin);
    logic c;
    c = 1'b0;
    unique case (op)
      OP_ADD: c = 1'b0;
      OP_SUB: c = 1'b1;
      OP_ADC: c = cin;
      OP_SBB: c = ~cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seg
// Purpose  : W-bit combinational ripple-carry slice with carry into its MSB.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_seg
  import pipe_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic carry;

  always_comb begin
    carry  = cin_i;
    s_o    = '0;
    cmsb_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cmsb_o = carry;
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Purpose  : Pipelined ADD/SUB/ADC/SBB, one SEG-bit ripple segment per stage.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [TAG_W-1:0] tag_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             flag_c_o,
  output logic             flag_v_o,
  output logic             flag_z_o,
  output logic             flag_n_o,
  output logic [TAG_W-1:0] tag_out_o
);

  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int STAGES   = (WIDTH / SEG_SAFE < 1) ? 1 : WIDTH / SEG_SAFE;

  generate
    if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_param_check
      $error("pipe_addsub: SEG must be >= 1 and divide WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0]     b_eff;
  logic                 carry0;
  logic [STAGES-1:0]    valid_q, adv, in_v;
  logic [WIDTH-1:0]     a_q [STAGES];
  logic [WIDTH-1:0]     b_q [STAGES];
  logic [WIDTH-1:0]     sum_q [STAGES];
  logic                 carry_q [STAGES];
  logic [TAG_W-1:0]     tag_q [STAGES];
  logic [WIDTH-1:0]     in_a [STAGES];
  logic [WIDTH-1:0]     in_b [STAGES];
  logic [WIDTH-1:0]     in_sum [STAGES];
  logic                 in_c [STAGES];
  logic [TAG_W-1:0]     in_tag [STAGES];
  logic [WIDTH-1:0]     sum_d [STAGES];
  logic [SEG_SAFE-1:0]  seg_s [STAGES];
  logic                 seg_co [STAGES];
  logic                 seg_cm [STAGES];
  logic [NUM_FLAGS-1:0] flags_q;

  assign b_eff  = op_i[0] ? ~b_i : b_i;
  assign carry0 = op_carry_in(op_e'(op_i), cin_i);

  // Operands travel right-shifted so the next segment is always at bit 0;
  // the sum fills in from the top and is aligned after the last stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign in_v[k]   = in_valid_i;
      assign in_a[k]   = a_i;
      assign in_b[k]   = b_eff;
      assign in_c[k]   = carry0;
      assign in_sum[k] = '0;
      assign in_tag[k] = tag_in_i;
    end else begin : g_body
      assign in_v[k]   = valid_q[k-1];
      assign in_a[k]   = a_q[k-1];
      assign in_b[k]   = b_q[k-1];
      assign in_c[k]   = carry_q[k-1];
      assign in_sum[k] = sum_q[k-1];
      assign in_tag[k] = tag_q[k-1];
    end

    addsub_seg #(.W(SEG_SAFE)) u_seg (
      .a_i    (in_a[k][SEG_SAFE-1:0]),
      .b_i    (in_b[k][SEG_SAFE-1:0]),
      .cin_i  (in_c[k]),
      .s_o    (seg_s[k]),
      .cout_o (seg_co[k]),
      .cmsb_o (seg_cm[k])
    );

    assign sum_d[k] = (in_sum[k] >> SEG_SAFE) | (WIDTH'(seg_s[k]) << (WIDTH - SEG_SAFE));
  end

  always_comb begin : p_adv
    logic r;
    adv = '0;
    r   = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = ~valid_q[k] | r;
      adv[k] = r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      flags_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= in_v[k];
          if (in_v[k]) begin
            a_q[k]     <= in_a[k] >> SEG_SAFE;
            b_q[k]     <= in_b[k] >> SEG_SAFE;
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= seg_co[k];
            tag_q[k]   <= in_tag[k];
          end
        end
      end
      if (adv[STAGES-1] && in_v[STAGES-1]) begin
        flags_q[FLAG_C] <= seg_co[STAGES-1];
        flags_q[FLAG_V] <= seg_cm[STAGES-1] ^ seg_co[STAGES-1];
        flags_q[FLAG_Z] <= ~|sum_d[STAGES-1];
        flags_q[FLAG_N] <= sum_d[STAGES-1][WIDTH-1];
      end
    end
  end

  assign in_ready_o  = adv[0];
  assign out_valid_o = valid_q[STAGES-1];
  assign sum_o       = sum_q[STAGES-1];
  assign tag_out_o   = tag_q[STAGES-1];
  assign flag_c_o    = flags_q[FLAG_C];
  assign flag_v_o    = flags_q[FLAG_V];
  assign flag_z_o    = flags_q[FLAG_Z];
  assign flag_n_o    = flags_q[FLAG_N];

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_addsub
// Purpose  : Directed self-checking bench for pipe_addsub (32/8, 16/16, 64/16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, sum;
  logic [3:0]  tag_in = '0, tag_out;
  logic        fc, fv, fz, fn;
  wire  [3:0]  flags = {fn, fz, fv, fc};

  logic        d16_in_valid = 1'b0, d16_in_ready, d16_out_valid, d16_fc, d16_fv, d16_fz, d16_fn;
  logic [15:0] d16_a = '0, d16_b = '0, d16_sum;
  logic [3:0]  d16_tag_out;
  logic        d64_in_valid = 1'b0, d64_in_ready, d64_out_valid, d64_fc, d64_fv, d64_fz, d64_fn;
  logic [63:0] d64_a = '0, d64_b = '0, d64_sum;
  logic [3:0]  d64_tag_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(32), .SEG(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .a_i(a), .b_i(b), .cin_i(cin), .tag_in_i(tag_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .sum_o(sum), .flag_c_o(fc), .flag_v_o(fv),
    .flag_z_o(fz), .flag_n_o(fn), .tag_out_o(tag_out));

  pipe_addsub #(.WIDTH(16), .SEG(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid_i(d16_in_valid), .in_ready_o(d16_in_ready), .op_i(2'b00),
    .a_i(d16_a), .b_i(d16_b), .cin_i(1'b0), .tag_in_i(4'h1), .out_valid_o(d16_out_valid),
    .out_ready_i(1'b1), .sum_o(d16_sum), .flag_c_o(d16_fc), .flag_v_o(d16_fv),
    .flag_z_o(d16_fz), .flag_n_o(d16_fn), .tag_out_o(d16_tag_out));

  pipe_addsub #(.WIDTH(64), .SEG(16), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid_i(d64_in_valid), .in_ready_o(d64_in_ready), .op_i(2'b00),
    .a_i(d64_a), .b_i(d64_b), .cin_i(1'b0), .tag_in_i(4'h2), .out_valid_o(d64_out_valid),
    .out_ready_i(1'b1), .sum_o(d64_sum), .flag_c_o(d64_fc), .flag_v_o(d64_fv),
    .flag_z_o(d64_fz), .flag_n_o(d64_fn), .tag_out_o(d64_tag_out));

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Offers one op on an empty pipeline and waits (bounded) for its result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [3:0] tt, output int lat,
                        output logic [31:0] s, output logic [3:0] f, output logic [3:0] t);
    op = o; a = ta; b = tb; cin = tc; tag_in = tt; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    s = sum; f = flags; t = tag_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    checks++; if (tag_out !== 4'h0) begin errors++; $display("FAIL reset_tag got %h want 0", tag_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if ((d16_out_valid | d64_out_valid) !== 1'b0) begin errors++; $display("FAIL reset_alt_valid got %b want 0", d16_out_valid | d64_out_valid); end
  endtask

  task automatic test_add_carry();
    int lat; logic [31:0] s; logic [3:0] f, t;
    drain();
    run_op(2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h1, lat, s, f, t);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL add_sum got %h want 00000000", s); end
    checks++; if (f !== 4'b0101) begin errors++; $display("FAIL add_flags got %b want 0101", f); end
    checks++; if (t !== 4'h1) begin errors++; $display("FAIL add_tag got %h want 1", t); end
    run_op(2'b00, 32'h1, 32'h1, 1'b1, 4'h2, lat, s, f, t);
    checks++; if (s !== 32'h2 || f !== 4'b0000) begin errors++; $display("FAIL add_cin_ignored got %h/%b want 00000002/0000", s, f); end
  endtask

  task automatic test_sub_sbb();
    int lat; logic [31:0] s; logic [3:0] f, t;
    drain();
    run_op(2'b01, 32'h8000_0000, 32'h1, 1'b0, 4'h3, lat, s, f, t);
    checks++; if (s !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_sum got %h want 7fffffff", s); end
    checks++; if (f !== 4'b0011) begin errors++; $display("FAIL sub_flags got %b want 0011", f); end
    run_op(2'b11, 32'h5, 32'h3, 1'b1, 4'h4, lat, s, f, t);
    checks++; if (s !== 32'h1 || f !== 4'b0001) begin errors++; $display("FAIL sbb_result got %h/%b want 00000001/0001", s, f); end
    run_op(2'b01, 32'h5, 32'h5, 1'b0, 4'h5, lat, s, f, t);
    checks++; if (s !== 32'h0 || f !== 4'b0101) begin errors++; $display("FAIL sub_zero got %h/%b want 00000000/0101", s, f); end
  endtask

  task automatic test_adc_overflow();
    int lat; logic [31:0] s; logic [3:0] f, t;
    drain();
    run_op(2'b10, 32'h7FFF_FFFF, 32'h0, 1'b1, 4'h6, lat, s, f, t);
    checks++; if (s !== 32'h8000_0000) begin errors++; $display("FAIL adc_sum got %h want 80000000", s); end
    checks++; if (f !== 4'b1010) begin errors++; $display("FAIL adc_flags got %b want 1010", f); end
    run_op(2'b00, 32'h7FFF_FFFF, 32'h0, 1'b1, 4'h7, lat, s, f, t);
    checks++; if (s !== 32'h7FFF_FFFF || f !== 4'b0000) begin errors++; $display("FAIL add_no_ovf got %h/%b want 7fffffff/0000", s, f); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  vop [6] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
    logic [31:0] va  [6] = '{32'h1, 32'hA, 32'hFFFF_0000, 32'h8, 32'h00FF_FFFF, 32'h0};
    logic [31:0] vb  [6] = '{32'h2, 32'h3, 32'h0001_0000, 32'h2, 32'h1, 32'h1};
    logic        vc  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vs  [6] = '{32'h3, 32'h7, 32'h0, 32'h6, 32'h0100_0001, 32'hFFFF_FFFF};
    int sent = 0, recv = 0, held = 0, cyc = 0, first_fire = -1, last_fire = -1;
    logic acc, fire;
    drain();
    out_ready = 1'b0;
    while (recv < 6 && cyc < 60) begin
      out_ready = (held >= 5);
      if (sent < 6) begin
        in_valid = 1'b1; op = vop[sent]; a = va[sent]; b = vb[sent]; cin = vc[sent]; tag_in = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc  = in_valid & in_ready;
      fire = out_valid & out_ready;
      if (out_valid && held < 5) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
        checks++; if (sum !== 32'h3 || tag_out !== 4'h0) begin errors++; $display("FAIL stall_hold got %h/%h want 00000003/0", sum, tag_out); end
        held++;
        if (held == 5) begin
          checks++; if (sent !== 4) begin errors++; $display("FAIL stall_accepted got %0d want 4", sent); end
        end
      end
      if (fire) begin
        checks++;
        if (sum !== vs[recv] || tag_out !== 4'(recv)) begin
          errors++; $display("FAIL b2b_result got %h/%h want %h/%h", sum, tag_out, vs[recv], 4'(recv));
        end
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        recv++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (recv !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", recv); end
    checks++; if (last_fire - first_fire !== 5) begin errors++; $display("FAIL b2b_throughput got span %0d want 5", last_fire - first_fire); end
  endtask

  task automatic test_reset_mid();
    int lat, seen = 0; logic [31:0] s; logic [3:0] f, t;
    drain();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 2'b00; a = 32'(i + 1); b = 32'h10; cin = 1'b0; tag_in = 4'(4'hA + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_ghost got %0d results want 0", seen); end
    run_op(2'b00, 32'h2, 32'h3, 1'b0, 4'hD, lat, s, f, t);
    checks++; if (lat !== 4 || s !== 32'h5 || t !== 4'hD) begin errors++; $display("FAIL midrst_fresh got lat %0d %h/%h want 4 00000005/d", lat, s, t); end
  endtask

  task automatic test_degenerate();
    int lat;
    drain();
    d16_a = 16'h8000; d16_b = 16'h8000; d16_in_valid = 1'b1;
    @(posedge clk); #1;
    d16_in_valid = 1'b0;
    lat = 1;
    while (!d16_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 1) begin errors++; $display("FAIL w16_latency got %0d want 1", lat); end
    checks++; if (d16_sum !== 16'h0 || {d16_fn, d16_fz, d16_fv, d16_fc} !== 4'b0111) begin
      errors++; $display("FAIL w16_result got %h/%b want 0000/0111", d16_sum, {d16_fn, d16_fz, d16_fv, d16_fc});
    end
    d64_a = 64'hFFFF_FFFF_FFFF_FFFF; d64_b = 64'h1; d64_in_valid = 1'b1;
    @(posedge clk); #1;
    d64_in_valid = 1'b0;
    lat = 1;
    while (!d64_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL w64_latency got %0d want 4", lat); end
    checks++; if (d64_sum !== 64'h0 || {d64_fn, d64_fz, d64_fv, d64_fc} !== 4'b0101) begin
      errors++; $display("FAIL w64_result got %h/%b want 0/0101", d64_sum, {d64_fn, d64_fz, d64_fv, d64_fc});
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_sbb();
    test_adc_overflow();
    test_back_to_back();
    test_reset_mid();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
